// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction-memory geometry, HALT opcode, fetch-state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Value of instr[31:26] that stops the fetch sequencer.
  localparam logic [5:0] OPC_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode handshake: one instruction word plus its address, valid/ready.
// Latency: n/a (wires only).
// Backpressure: the producer holds if_instr/if_pc while if_valid && !if_ready.
//   master : fetch side   (drives if_valid, if_instr, if_pc; samples if_ready)
//   slave  : decode side  (samples if_valid, if_instr, if_pc; drives if_ready)
interface fetch_ctrl_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads instr_mem combinationally, registers the word for decode.
// Latency: start at edge N -> PC loaded at N, first if_valid after N+1; 1 instr/cycle; 1-cycle bubble per redirect.
// Backpressure: if_valid && !if_ready holds pc, if_instr, if_pc and if_valid.
//   clk, rst                 : clock, synchronous active-high reset
//   start, start_pc          : begin fetching from start_pc (IDLE only)
//   redirect_valid/_pc       : flush the output stage and refetch from redirect_pc (RUN/HALT)
//   imem_addr / imem_instr   : combinational read port of instr_mem
//   dec (fetch_ctrl_if)      : registered instruction toward decode
//   busy / halted            : state == RUN / state == HALT
module fetch_ctrl #(
  parameter int         ADDR_W   = cpu_pkg::ADDR_W,
  parameter int         DATA_W   = cpu_pkg::DATA_W,
  parameter logic [5:0] HALT_OPC = cpu_pkg::OPC_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  fetch_ctrl_if.master      dec,
  output logic              busy,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic load;
  logic halt_word;

  // The output stage can take a new word when empty or when decode drains it this cycle.
  assign load      = !vld_q || dec.if_ready;
  assign halt_word = (imem_instr[DATA_W-1 -: 6] == HALT_OPC);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // redirect_valid has no meaning before the first start.
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid)         state_d = RUN;
        else if (load && halt_word) state_d = HALT;
      end
      HALT: begin
        if (redirect_valid) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- status outputs
  always_comb begin
    busy   = (state_q == RUN);
    halted = (state_q == HALT);
  end

  // ---------------------------------------------------------------- datapath next-state
  always_comb begin
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        if (start) pc_d = start_pc;
      end
      RUN, HALT: begin
        if (redirect_valid) begin
          // Flush wins over a same-cycle handshake: the word on if_* is dropped.
          pc_d  = redirect_pc;
          vld_d = 1'b0;
        end else if (state_q == RUN && load) begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          // The HALT word is delivered, but the PC stays parked on it.
          if (!halt_word) pc_d = pc_q + 1'b1;
        end else if (state_q == HALT && vld_q && dec.if_ready) begin
          vld_d = 1'b0;
        end
      end
      default: begin
        vld_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign dec.if_valid = vld_q;
  assign dec.if_instr = instr_q;
  assign dec.if_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  start_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic [4:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        busy;
  logic        halted;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if ifc ();

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .dec            (ifc.master),
    .busy           (busy),
    .halted         (halted)
  );

  // instr_mem model: mem[i] = 0x1000 + i, except a HALT word at address 6.
  always_comb begin
    if (imem_addr == 5'd6) imem_instr = 32'hFC00_0000;
    else                   imem_instr = 32'h0000_1000 + {27'd0, imem_addr};
  end

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Check the registered output stage against expected valid/pc/instr.
  task automatic chk_out(input string name, input logic ev, input logic [4:0] epc, input logic [31:0] ei);
    checks++;
    if (ifc.if_valid !== ev || (ev && (ifc.if_pc !== epc || ifc.if_instr !== ei)))
      $display("FAIL %s: got v=%0b pc=%0d instr=%h, want v=%0b pc=%0d instr=%h",
               name, ifc.if_valid, ifc.if_pc, ifc.if_instr, ev, epc, ei);
    else passed++;
  endtask

  task automatic chk_st(input string name, input logic [4:0] eaddr, input logic eb, input logic eh);
    checks++;
    if (imem_addr !== eaddr || busy !== eb || halted !== eh)
      $display("FAIL %s: got addr=%0d busy=%0b halted=%0b, want addr=%0d busy=%0b halted=%0b",
               name, imem_addr, busy, halted, eaddr, eb, eh);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start_pc = 5'd9; redirect_valid = 1'b0; redirect_pc = 5'd0;
    ifc.if_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (ifc.if_valid !== 1'b0 || ifc.if_pc !== 5'd0 || ifc.if_instr !== 32'd0)
      $display("FAIL reset_out: got v=%0b pc=%0d instr=%h, want 0/0/0", ifc.if_valid, ifc.if_pc, ifc.if_instr);
    else passed++;
    chk_st("reset_state", 5'd0, 1'b0, 1'b0);
    // Redirect in IDLE must be ignored.
    redirect_valid = 1'b1; redirect_pc = 5'd9;
    tick();
    redirect_valid = 1'b0;
    chk_st("idle_redirect_ignored", 5'd0, 1'b0, 1'b0);
    chk_out("idle_no_valid", 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_stream_halt();
    do_reset();
    ifc.if_ready = 1'b1;
    start = 1'b1; start_pc = 5'd0;
    tick();
    start = 1'b0;
    chk_st("start_pc_loaded", 5'd0, 1'b1, 1'b0);
    chk_out("start_bubble", 1'b0, 5'd0, 32'd0);
    tick();
    chk_out("first_word", 1'b1, 5'd0, 32'h1000);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk_out("stream_word", 1'b1, 5'(i), 32'h1000 + i);
    end
    tick();
    chk_out("halt_word", 1'b1, 5'd6, 32'hFC00_0000);
    chk_st("halt_state", 5'd6, 1'b0, 1'b1);
    tick();
    chk_out("halt_drained", 1'b0, 5'd0, 32'd0);
    // start is ignored in HALT.
    start = 1'b1; start_pc = 5'd1;
    tick();
    start = 1'b0;
    tick();
    chk_st("halt_start_ignored", 5'd6, 1'b0, 1'b1);
    chk_out("halt_no_fetch", 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_backpressure();
    do_reset();
    ifc.if_ready = 1'b0;
    start = 1'b1; start_pc = 5'd2;
    tick();
    start = 1'b0;
    tick();
    chk_out("bp_first", 1'b1, 5'd2, 32'h1002);
    chk_st("bp_pc_first", 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 5'd2, 32'h1002);
      chk_st("bp_pc_hold", 5'd3, 1'b1, 1'b0);
    end
    ifc.if_ready = 1'b1;
    tick();
    chk_out("bp_release", 1'b1, 5'd3, 32'h1003);
    chk_st("bp_pc_release", 5'd4, 1'b1, 1'b0);
  endtask

  task automatic test_redirect();
    do_reset();
    ifc.if_ready = 1'b1;
    start = 1'b1; start_pc = 5'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_st("redir_at_pc4", 5'd4, 1'b1, 1'b0);
    chk_out("redir_pre", 1'b1, 5'd3, 32'h1003);
    redirect_valid = 1'b1; redirect_pc = 5'd20;
    tick();
    redirect_valid = 1'b0;
    chk_out("redir_flush", 1'b0, 5'd0, 32'd0);
    chk_st("redir_pc", 5'd20, 1'b1, 1'b0);
    tick();
    chk_out("redir_target", 1'b1, 5'd20, 32'h1014);
    tick();
    chk_out("redir_next", 1'b1, 5'd21, 32'h1015);
  endtask

  task automatic test_wrap_resume();
    logic [4:0] exp_pc;
    do_reset();
    ifc.if_ready = 1'b1;
    start = 1'b1; start_pc = 5'd30;
    tick();
    start = 1'b0;
    exp_pc = 5'd30;
    // 30, 31, 0, 1 ... 5 then the HALT word at 6.
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("wrap_seq", 1'b1, exp_pc, 32'h1000 + {27'd0, exp_pc});
      exp_pc = exp_pc + 5'd1;
    end
    tick();
    chk_out("wrap_halt_word", 1'b1, 5'd6, 32'hFC00_0000);
    chk_st("wrap_halted", 5'd6, 1'b0, 1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 5'd10;
    tick();
    redirect_valid = 1'b0;
    chk_st("resume_state", 5'd10, 1'b1, 1'b0);
    chk_out("resume_bubble", 1'b0, 5'd0, 32'd0);
    tick();
    chk_out("resume_word", 1'b1, 5'd10, 32'h100A);
  endtask

  task automatic test_midrun_reset();
    do_reset();
    ifc.if_ready = 1'b1;
    start = 1'b1; start_pc = 5'd0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk_out("mid_pre", 1'b1, 5'd2, 32'h1002);
    rst = 1'b1; start = 1'b1; start_pc = 5'd5;
    tick();
    checks++;
    if (ifc.if_valid !== 1'b0 || ifc.if_instr !== 32'd0 || ifc.if_pc !== 5'd0)
      $display("FAIL mid_reset_out: got v=%0b pc=%0d instr=%h, want 0/0/0", ifc.if_valid, ifc.if_pc, ifc.if_instr);
    else passed++;
    chk_st("mid_reset_state", 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; start = 1'b0;
    chk_st("mid_reset_start_ignored", 5'd0, 1'b0, 1'b0);
    tick();
    chk_st("mid_reset_idle", 5'd0, 1'b0, 1'b0);
    chk_out("mid_reset_no_valid", 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
    ifc.if_ready = 1'b0;
    #1;
    test_reset();
    test_stream_halt();
    test_backpressure();
    test_redirect();
    test_wrap_resume();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
